// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline stall/flush sequencer.
// State encoding, control bundle and load-use helper.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        DRAIN    = 2'd2,
        HALTED   = 2'd3
    } ctrl_state_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic pc_we;
        logic ifid_we;
        logic ifid_fl;
        logic idex_we;
        logic idex_fl;
        logic exmem_we;
        logic memwb_we;
    } ctrl_t;

    localparam ctrl_t CTRL_HOLD = '0;

    localparam ctrl_t CTRL_RUN = '{
        pc_we:    1'b1,
        ifid_we:  1'b1,
        ifid_fl:  1'b0,
        idex_we:  1'b1,
        idex_fl:  1'b0,
        exmem_we: 1'b1,
        memwb_we: 1'b1
    };

    localparam ctrl_t CTRL_BRANCH = '{
        pc_we:    1'b1,
        ifid_we:  1'b1,
        ifid_fl:  1'b1,
        idex_we:  1'b1,
        idex_fl:  1'b1,
        exmem_we: 1'b1,
        memwb_we: 1'b1
    };

    // Hold PC and IF/ID, push a bubble into EX.
    localparam ctrl_t CTRL_LOADUSE = '{
        pc_we:    1'b0,
        ifid_we:  1'b0,
        ifid_fl:  1'b0,
        idex_we:  1'b1,
        idex_fl:  1'b1,
        exmem_we: 1'b1,
        memwb_we: 1'b1
    };

    // Stop fetching, let older instructions retire.
    localparam ctrl_t CTRL_DRAIN = '{
        pc_we:    1'b0,
        ifid_we:  1'b0,
        ifid_fl:  1'b1,
        idex_we:  1'b1,
        idex_fl:  1'b0,
        exmem_we: 1'b1,
        memwb_we: 1'b1
    };

    function automatic logic load_use(
        input logic       mem_rd,
        input logic [4:0] rd,
        input logic       use1,
        input logic [4:0] rs1,
        input logic       use2,
        input logic [4:0] rs2
    );
        logic m1;
        logic m2;
        m1 = use1 & (rs1 == rd);
        m2 = use2 & (rs2 == rd);
        return mem_rd & (rd != REG_ZERO) & (m1 | m2);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter for the performance report.
// Sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         CLK,
    input  logic         RSTn,
    input  logic         inc,
    output logic [W-1:0] count
);

    // Count events, holding at the maximum value.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage RV32I pipeline.
// Handles load-use, branch flush, dmem wait and halt drain.
module pipeline_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int CNT_W        = 32,
    parameter int MEM_TIMEOUT  = 16,
    parameter int DRAIN_CYCLES = 3
) (
    input  logic             CLK,
    input  logic             RSTn,
    input  logic [4:0]       RS1_ID,
    input  logic [4:0]       RS2_ID,
    input  logic             useRS1_ID,
    input  logic             useRS2_ID,
    input  logic [4:0]       RD_EX,
    input  logic             memRead_EX,
    input  logic             branchTaken_EX,
    input  logic             halt_ID,
    input  logic             dmemReq_MEM,
    input  logic             dmemReady_MEM,
    output logic             pcWrite,
    output logic             ifidWrite,
    output logic             ifidFlush,
    output logic             idexWrite,
    output logic             idexFlush,
    output logic             exmemWrite,
    output logic             memwbWrite,
    output logic             halted,
    output logic             memErr,
    output logic [CNT_W-1:0] stallCnt,
    output logic [CNT_W-1:0] flushCnt
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
    localparam int DRN_W  =
        (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    localparam logic [WAIT_W-1:0] WAIT_LAST =
        WAIT_W'(MEM_TIMEOUT - 1);
    localparam logic [DRN_W-1:0] DRN_LAST =
        DRN_W'(DRAIN_CYCLES - 1);

    ctrl_state_t       state;
    logic [WAIT_W-1:0] wait_cnt;
    logic [DRN_W-1:0]  drain_cnt;
    ctrl_t             ctrl;

    logic freeze;
    logic run_mode;
    logic hit;
    logic do_freeze;
    logic do_branch;
    logic do_lu;
    logic do_plain;
    logic do_halt;
    logic draining;
    logic wait_last;
    logic stall_inc;

    assign freeze    = dmemReq_MEM & ~dmemReady_MEM;
    assign run_mode  = (state == RUN) | (state == MEM_WAIT);
    assign hit       = load_use(memRead_EX, RD_EX,
                                useRS1_ID, RS1_ID,
                                useRS2_ID, RS2_ID);
    assign do_freeze = freeze & (state != HALTED);
    assign do_branch = run_mode & ~freeze & branchTaken_EX;
    assign do_lu     = run_mode & ~freeze
                     & ~branchTaken_EX & hit;
    assign do_plain  = run_mode & ~freeze
                     & ~branchTaken_EX & ~hit;
    assign do_halt   = do_plain & halt_ID;
    assign draining  = (state == DRAIN) & ~freeze;
    assign wait_last = (wait_cnt == WAIT_LAST);

    // Select the stage controls for this cycle; all off in reset.
    always_comb begin
        ctrl = CTRL_HOLD;
        if (RSTn) begin
            unique case (1'b1)
                do_freeze: ctrl = CTRL_HOLD;
                do_branch: ctrl = CTRL_BRANCH;
                do_lu:     ctrl = CTRL_LOADUSE;
                do_plain:  ctrl = CTRL_RUN;
                draining:  ctrl = CTRL_DRAIN;
                default:   ctrl = CTRL_HOLD;
            endcase
        end
    end

    assign pcWrite    = ctrl.pc_we;
    assign ifidWrite  = ctrl.ifid_we;
    assign ifidFlush  = ctrl.ifid_fl;
    assign idexWrite  = ctrl.idex_we;
    assign idexFlush  = ctrl.idex_fl;
    assign exmemWrite = ctrl.exmem_we;
    assign memwbWrite = ctrl.memwb_we;

    // Sequence state, wait/drain counts and sticky flags.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state     <= RUN;
            wait_cnt  <= '0;
            drain_cnt <= '0;
            halted    <= 1'b0;
            memErr    <= 1'b0;
        end else begin
            unique case (state)
                RUN, MEM_WAIT: begin
                    if (freeze) begin
                        if (wait_last) begin
                            memErr   <= 1'b1;
                            state    <= HALTED;
                            wait_cnt <= '0;
                        end else begin
                            state    <= MEM_WAIT;
                            wait_cnt <= wait_cnt + 1'b1;
                        end
                    end else begin
                        wait_cnt <= '0;
                        if (do_halt) begin
                            state     <= DRAIN;
                            drain_cnt <= '0;
                        end else begin
                            state <= RUN;
                        end
                    end
                end
                DRAIN: begin
                    if (freeze) begin
                        if (wait_last) begin
                            memErr   <= 1'b1;
                            state    <= HALTED;
                            wait_cnt <= '0;
                        end else begin
                            wait_cnt <= wait_cnt + 1'b1;
                        end
                    end else begin
                        wait_cnt <= '0;
                        if (drain_cnt == DRN_LAST) begin
                            state  <= HALTED;
                            halted <= 1'b1;
                        end else begin
                            drain_cnt <= drain_cnt + 1'b1;
                        end
                    end
                end
                HALTED: begin
                    state <= HALTED;
                end
                default: begin
                    state <= RUN;
                end
            endcase
        end
    end

    assign stall_inc = run_mode & ~ctrl.pc_we;

    sat_counter #(
        .W (CNT_W)
    ) u_stall_cnt (
        .CLK   (CLK),
        .RSTn  (RSTn),
        .inc   (stall_inc),
        .count (stallCnt)
    );

    sat_counter #(
        .W (CNT_W)
    ) u_flush_cnt (
        .CLK   (CLK),
        .RSTn  (RSTn),
        .inc   (do_branch),
        .count (flushCnt)
    );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl.
// Directed scenarios followed by random traffic vs a model.
module tb_pipeline_hazard_ctrl;

    localparam int CNT_W = 32;
    localparam int TO    = 16;
    localparam int DC    = 3;

    logic             CLK = 1'b0;
    logic             RSTn = 1'b0;
    logic [4:0]       RS1_ID;
    logic [4:0]       RS2_ID;
    logic             useRS1_ID;
    logic             useRS2_ID;
    logic [4:0]       RD_EX;
    logic             memRead_EX;
    logic             branchTaken_EX;
    logic             halt_ID;
    logic             dmemReq_MEM;
    logic             dmemReady_MEM;
    logic             pcWrite;
    logic             ifidWrite;
    logic             ifidFlush;
    logic             idexWrite;
    logic             idexFlush;
    logic             exmemWrite;
    logic             memwbWrite;
    logic             halted;
    logic             memErr;
    logic [CNT_W-1:0] stallCnt;
    logic [CNT_W-1:0] flushCnt;

    pipeline_hazard_ctrl #(
        .CNT_W        (CNT_W),
        .MEM_TIMEOUT  (TO),
        .DRAIN_CYCLES (DC)
    ) dut (
        .CLK            (CLK),
        .RSTn           (RSTn),
        .RS1_ID         (RS1_ID),
        .RS2_ID         (RS2_ID),
        .useRS1_ID      (useRS1_ID),
        .useRS2_ID      (useRS2_ID),
        .RD_EX          (RD_EX),
        .memRead_EX     (memRead_EX),
        .branchTaken_EX (branchTaken_EX),
        .halt_ID        (halt_ID),
        .dmemReq_MEM    (dmemReq_MEM),
        .dmemReady_MEM  (dmemReady_MEM),
        .pcWrite        (pcWrite),
        .ifidWrite      (ifidWrite),
        .ifidFlush      (ifidFlush),
        .idexWrite      (idexWrite),
        .idexFlush      (idexFlush),
        .exmemWrite     (exmemWrite),
        .memwbWrite     (memwbWrite),
        .halted         (halted),
        .memErr         (memErr),
        .stallCnt       (stallCnt),
        .flushCnt       (flushCnt)
    );

    always #5 CLK = ~CLK;

    int checks   = 0;
    int failures = 0;

    // Reference model: plain counters and flags.
    int m_waits;
    int m_drain_left;
    longint m_stall;
    longint m_flush;
    bit m_halted;
    bit m_err;

    function automatic void model_reset();
        m_waits      = 0;
        m_drain_left = 0;
        m_stall      = 0;
        m_flush      = 0;
        m_halted     = 0;
        m_err        = 0;
    endfunction

    function automatic bit lu_match();
        bit a;
        bit b;
        a = useRS1_ID && (RS1_ID == RD_EX);
        b = useRS2_ID && (RS2_ID == RD_EX);
        return memRead_EX && (RD_EX != 5'd0) && (a || b);
    endfunction

    function automatic bit fz();
        return dmemReq_MEM && !dmemReady_MEM;
    endfunction

    // {pc, ifidW, ifidF, idexW, idexF, exmemW, memwbW}
    function automatic logic [6:0] exp_ctrl();
        if (!RSTn) return 7'b0000000;
        if (m_halted || m_err) return 7'b0000000;
        if (fz()) return 7'b0000000;
        if (m_drain_left > 0) return 7'b0011011;
        if (branchTaken_EX) return 7'b1111111;
        if (lu_match()) return 7'b0001111;
        return 7'b1101011;
    endfunction

    function automatic void model_edge();
        if (!RSTn || m_halted || m_err) return;
        if (fz()) begin
            if (m_drain_left == 0) m_stall++;
            m_waits++;
            if (m_waits == TO) m_err = 1;
        end else begin
            m_waits = 0;
            if (m_drain_left > 0) begin
                m_drain_left--;
                if (m_drain_left == 0) m_halted = 1;
            end else if (branchTaken_EX) begin
                m_flush++;
            end else if (lu_match()) begin
                m_stall++;
            end else if (halt_ID) begin
                m_drain_left = DC;
            end
        end
    endfunction

    task automatic chk(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h",
                   tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic [6:0] c;
        c = {pcWrite, ifidWrite, ifidFlush, idexWrite,
             idexFlush, exmemWrite, memwbWrite};
        chk({tag, ".ctrl"}, 64'(c), 64'(exp_ctrl()));
        chk({tag, ".halted"}, 64'(halted), 64'(m_halted));
        chk({tag, ".memErr"}, 64'(memErr), 64'(m_err));
        chk({tag, ".stallCnt"}, 64'(stallCnt), 64'(m_stall));
        chk({tag, ".flushCnt"}, 64'(flushCnt), 64'(m_flush));
    endtask

    task automatic clear_in();
        RS1_ID         = 5'd0;
        RS2_ID         = 5'd0;
        useRS1_ID      = 1'b0;
        useRS2_ID      = 1'b0;
        RD_EX          = 5'd0;
        memRead_EX     = 1'b0;
        branchTaken_EX = 1'b0;
        halt_ID        = 1'b0;
        dmemReq_MEM    = 1'b0;
        dmemReady_MEM  = 1'b0;
    endtask

    // Inputs are set at the falling edge; check, then clock.
    task automatic tick(input string tag);
        #1;
        check_all(tag);
        model_edge();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic do_reset();
        RSTn = 1'b0;
        model_reset();
        #1;
        check_all("reset");
        @(negedge CLK);
        RSTn = 1'b1;
    endtask

    task automatic freeze_in();
        clear_in();
        dmemReq_MEM   = 1'b1;
        dmemReady_MEM = 1'b0;
    endtask

    int stop_cycles;

    initial begin
        clear_in();
        model_reset();
        do_reset();

        tick("idle");

        // load-use on rs1
        memRead_EX = 1'b1;
        RD_EX      = 5'd5;
        useRS1_ID  = 1'b1;
        RS1_ID     = 5'd5;
        tick("lu_rs1");
        clear_in();
        tick("lu_after");

        // load-use on rs2
        memRead_EX = 1'b1;
        RD_EX      = 5'd9;
        useRS2_ID  = 1'b1;
        RS2_ID     = 5'd9;
        tick("lu_rs2");

        // rd = x0 never stalls
        clear_in();
        memRead_EX = 1'b1;
        useRS1_ID  = 1'b1;
        tick("lu_x0");

        // branch with load-use and halt in same cycle
        memRead_EX     = 1'b1;
        RD_EX          = 5'd7;
        useRS1_ID      = 1'b1;
        RS1_ID         = 5'd7;
        halt_ID        = 1'b1;
        branchTaken_EX = 1'b1;
        tick("br_haz");
        clear_in();
        tick("br_after");

        // dmem wait for 4 cycles then ready
        for (int i = 0; i < 4; i++) begin
            freeze_in();
            tick("memwait");
        end
        dmemReq_MEM   = 1'b1;
        dmemReady_MEM = 1'b1;
        tick("mem_ready");
        clear_in();
        tick("mem_after");

        // request and ready together
        dmemReq_MEM   = 1'b1;
        dmemReady_MEM = 1'b1;
        tick("mem_same");
        clear_in();

        // halt drain with a 2-cycle freeze inside
        halt_ID = 1'b1;
        tick("halt_in");
        clear_in();
        tick("drain1");
        freeze_in();
        tick("drain_fz1");
        tick("drain_fz2");
        clear_in();
        tick("drain2");
        tick("drain3");
        for (int i = 0; i < 3; i++) begin
            branchTaken_EX = 1'b1;
            halt_ID        = 1'b1;
            tick("halted");
        end

        // async reset mid-wait, between edges
        clear_in();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            freeze_in();
            tick("pre_rst_wait");
        end
        #2;
        RSTn = 1'b0;
        model_reset();
        #1;
        check_all("async_rst");
        @(negedge CLK);
        RSTn = 1'b1;
        clear_in();
        tick("post_rst");
        tick("post_rst2");

        // dmem timeout
        for (int i = 0; i < TO; i++) begin
            freeze_in();
            tick("timeout");
        end
        for (int i = 0; i < 3; i++) begin
            clear_in();
            dmemReq_MEM   = 1'b1;
            dmemReady_MEM = 1'b1;
            tick("err_sticky");
        end

        // random traffic
        clear_in();
        do_reset();
        stop_cycles = 0;
        for (int n = 0; n < 3000; n++) begin
            if (m_halted || m_err) begin
                stop_cycles++;
                if (stop_cycles > 3) begin
                    stop_cycles = 0;
                    clear_in();
                    do_reset();
                end
            end
            memRead_EX     = ($urandom % 3) == 0;
            RD_EX          = 5'($urandom % 4);
            RS1_ID         = 5'($urandom % 4);
            RS2_ID         = 5'($urandom % 4);
            useRS1_ID      = 1'($urandom % 2);
            useRS2_ID      = 1'($urandom % 2);
            branchTaken_EX = ($urandom % 6) == 0;
            halt_ID        = ($urandom % 25) == 0;
            dmemReq_MEM    = ($urandom % 3) == 0;
            dmemReady_MEM  = ($urandom % 4) == 0;
            tick("rand");
        end

        #1;
        check_all("final");
        $display("TB_RESULT checks=%0d failures=%0d",
                 checks, failures);
        $finish;
    end

endmodule
